// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared types and parameter helpers for pipe_adder_n
package pipe_adder_pkg;

  // Per-stage control word: the valid bit tags a real operation (vs. a bubble);
  // carry is the carry out of the chunk that stage has just added.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  // Bits handled by each pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // WIDTH must split evenly into STAGES slices of at least one bit.
  function automatic bit params_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// rtl/adder_stage.sv - one CHUNK-bit slice of the adder plus its pipeline register
module adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDX   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_advance,
  input  stage_ctrl_t       i_ctrl,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [WIDTH-1:0]  i_sum,
  output stage_ctrl_t       o_ctrl,
  output logic [WIDTH-1:0]  o_a,
  output logic [WIDTH-1:0]  o_b,
  output logic [WIDTH-1:0]  o_sum
);

  localparam int LSB = IDX * CHUNK;

  logic [CHUNK:0]     w_chunk;
  logic [WIDTH-1:0]   w_sum;
  stage_ctrl_t        r_ctrl;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;

  // Add this stage's slice with the incoming carry and splice it into the partial sum.
  always_comb begin
    w_chunk = {1'b0, i_a[LSB +: CHUNK]} + {1'b0, i_b[LSB +: CHUNK]}
            + {{CHUNK{1'b0}}, i_ctrl.carry};
    w_sum = i_sum;
    w_sum[LSB +: CHUNK] = w_chunk[CHUNK-1:0];
  end

  // Pipeline register: the operands travel along so later stages can add their slices.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctrl <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
    end else if (i_advance) begin
      r_ctrl.valid <= i_ctrl.valid;
      r_ctrl.carry <= w_chunk[CHUNK];
      r_a          <= i_a;
      r_b          <= i_b;
      r_sum        <= w_sum;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_a    = r_a;
  assign o_b    = r_b;
  assign o_sum  = r_sum;

endmodule

// File: rtl/pipe_adder_n.sv
// rtl/pipe_adder_n.sv - pipelined chunked adder/subtractor with valid/ready; ADD_OVERFLOW_EN enables OV
module pipe_adder_n
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Enable,
  input  logic              InValid,
  output logic              InReady,
  input  logic [WIDTH-1:0]  In1,
  input  logic [WIDTH-1:0]  In2,
  input  logic              CI,
  input  logic              Sub,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WIDTH-1:0]  Out,
  output logic              CO,
  output logic              OV
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_adder_n: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Index k is the input of stage k; index STAGES is the last stage's register,
  // which doubles as the output register.
  stage_ctrl_t       w_ctrl [STAGES+1];
  logic [WIDTH-1:0]  w_a    [STAGES+1];
  logic [WIDTH-1:0]  w_b    [STAGES+1];
  logic [WIDTH-1:0]  w_sum  [STAGES+1];
  logic              w_advance;
  logic              w_unused_tail;

  // The whole pipeline moves together; a held result blocks every stage behind it.
  assign w_advance = Enable & (~OutValid | OutReady);
  assign InReady   = w_advance;

  // Subtraction is A + ~B + 1, so the operand is inverted once at entry and CI is replaced.
  assign w_ctrl[0] = '{valid: InValid & w_advance, carry: (Sub ? 1'b1 : CI)};
  assign w_a[0]    = In1;
  assign w_b[0]    = Sub ? ~In2 : In2;
  assign w_sum[0]  = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_advance (w_advance),
      .i_ctrl    (w_ctrl[k]),
      .i_a       (w_a[k]),
      .i_b       (w_b[k]),
      .i_sum     (w_sum[k]),
      .o_ctrl    (w_ctrl[k+1]),
      .o_a       (w_a[k+1]),
      .o_b       (w_b[k+1]),
      .o_sum     (w_sum[k+1])
    );
  end

  assign OutValid = w_ctrl[STAGES].valid;
  assign Out      = w_sum[STAGES];
  assign CO       = w_ctrl[STAGES].carry;

`ifdef ADD_OVERFLOW_EN
  logic w_msb_cin;
  // Carry into the MSB recovered from the registered MSB operand and sum bits.
  assign w_msb_cin     = w_a[STAGES][WIDTH-1] ^ w_b[STAGES][WIDTH-1] ^ w_sum[STAGES][WIDTH-1];
  assign OV            = w_msb_cin ^ CO;
`else
  assign OV            = 1'b0;
`endif
  // Operands leaving the last stage are only needed for the overflow bit.
  assign w_unused_tail = ^{w_a[STAGES], w_b[STAGES]};

endmodule

// File: tb/tb_pipe_adder_n.sv
// tb/tb_pipe_adder_n.sv - self-checking bench for pipe_adder_n
module tb_pipe_adder_n;

  localparam int W = 32;
  localparam int S = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic         co;
    logic         ov;
  } res_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Enable;
  logic          InValid;
  logic          InReady;
  logic [W-1:0]  In1;
  logic [W-1:0]  In2;
  logic          CI;
  logic          Sub;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  Out;
  logic          CO;
  logic          OV;

  int checks = 0;
  int errors = 0;

`ifdef ADD_OVERFLOW_EN
  localparam logic OV_EN = 1'b1;
`else
  localparam logic OV_EN = 1'b0;
`endif

  always #5 CLK = ~CLK;

  pipe_adder_n #(.WIDTH(W), .STAGES(S)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Enable   (Enable),
    .InValid  (InValid),
    .InReady  (InReady),
    .In1      (In1),
    .In2      (In2),
    .CI       (CI),
    .Sub      (Sub),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Out      (Out),
    .CO       (CO),
    .OV       (OV)
  );

  // Reference: plain integer arithmetic, signed overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    res_t        r;
    logic [W:0]  full;
    if (sub) begin
      r.out = a - b;
      r.co  = (a >= b);
      r.ov  = OV_EN && (a[W-1] != b[W-1]) && (r.out[W-1] != a[W-1]);
    end else begin
      full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      r.out = full[W-1:0];
      r.co  = full[W];
      r.ov  = OV_EN && (a[W-1] == b[W-1]) && (r.out[W-1] != a[W-1]);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one op into an empty pipeline and wait (bounded) for its result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sub, output res_t got, output int lat);
    Enable = 1; OutReady = 1;
    In1 = a; In2 = b; CI = ci; Sub = sub; InValid = 1;
    tick();
    InValid = 0;
    lat = 1;
    while (OutValid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    got = '{out: Out, co: CO, ov: OV};
    tick();
  endtask

  task automatic test_reset();
    RST = 1; Enable = 0; InValid = 0; OutReady = 0;
    In1 = '0; In2 = '0; CI = 0; Sub = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    #1;
    checks++;
    if ({OutValid, Out, CO, OV} !== '0)
      $display("FAIL reset_state: got v=%b out=%h co=%b ov=%b want all 0", OutValid, Out, CO, OV);
    if ({OutValid, Out, CO, OV} !== '0) errors++;
    Enable = 1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_inready: got %b want 1", InReady);
    end
    tick();
  endtask

  task automatic test_add();
    res_t got; int lat;
    do_op(32'h3E037E1A, 32'h5ED86C3D, 1'b1, 1'b0, got, lat);
    checks++;
    if (got !== res_t'{out: 32'h9CDBEA58, co: 1'b0, ov: OV_EN}) begin
      errors++;
      $display("FAIL add_result: got %h/%b/%b want 9cdbea58/0/%b", got.out, got.co, got.ov, OV_EN);
    end
    checks++;
    if (lat !== S) begin
      errors++;
      $display("FAIL add_latency: got %0d want %0d", lat, S);
    end
  endtask

  task automatic test_ripple();
    res_t got; int lat;
    do_op(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, got, lat);
    checks++;
    if (got !== res_t'{out: 32'h0, co: 1'b1, ov: 1'b0}) begin
      errors++;
      $display("FAIL ripple_result: got %h/%b/%b want 00000000/1/0", got.out, got.co, got.ov);
    end
  endtask

  task automatic test_subtract();
    res_t got; int lat;
    do_op(32'd5, 32'd7, 1'b1, 1'b1, got, lat);
    checks++;
    if (got !== res_t'{out: 32'hFFFFFFFE, co: 1'b0, ov: 1'b0}) begin
      errors++;
      $display("FAIL sub_5_7: got %h/%b/%b want fffffffe/0/0", got.out, got.co, got.ov);
    end
    do_op(32'd7, 32'd5, 1'b1, 1'b1, got, lat);
    checks++;
    if (got !== res_t'{out: 32'd2, co: 1'b1, ov: 1'b0}) begin
      errors++;
      $display("FAIL sub_7_5: got %h/%b/%b want 00000002/1/0", got.out, got.co, got.ov);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got [8];
    logic [W-1:0] held;
    int sent, got_n, cyc;
    sent = 0; got_n = 0; cyc = 0; held = '0;
    Enable = 1; CI = 0; Sub = 0;
    while (got_n < 4 && cyc < 60) begin
      InValid = (sent < 4);
      In1 = W'(sent + 1); In2 = W'(sent + 1);
      OutReady = !(cyc >= 5 && cyc < 8);
      #1;
      if (!OutReady && OutValid) begin
        checks++;
        if (InReady !== 1'b0) begin
          errors++;
          $display("FAIL bp_inready_stalled: got %b want 0 (cycle %0d)", InReady, cyc);
        end
        if (cyc == 5) held = Out;
        else begin
          checks++;
          if (Out !== held) begin
            errors++;
            $display("FAIL bp_out_stable: got %h want %h (cycle %0d)", Out, held, cyc);
          end
        end
      end
      if (InValid && InReady) sent++;
      if (OutValid && OutReady) begin
        if (got_n < 8) got[got_n] = Out;
        got_n++;
      end
      tick();
      cyc++;
    end
    InValid = 0; OutReady = 1;
    checks++;
    if (got_n != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d results want 4", got_n);
    end
    for (int i = 0; i < 4 && i < got_n; i++) begin
      checks++;
      if (got[i] !== W'(2 * (i + 1))) begin
        errors++;
        $display("FAIL bp_value[%0d]: got %0d want %0d", i, got[i], 2 * (i + 1));
      end
    end
    repeat (S + 2) begin
      checks++;
      if (OutValid !== 1'b0) begin
        errors++;
        $display("FAIL bp_no_duplicate: got OutValid=%b want 0", OutValid);
      end
      tick();
    end
  endtask

  task automatic test_enable();
    logic         v0;
    logic [W-1:0] o0;
    int t;
    Enable = 1; OutReady = 1; CI = 0; Sub = 0;
    In1 = 32'd10; In2 = 32'd20; InValid = 1;
    tick();
    In1 = 32'd30; In2 = 32'd40;
    tick();
    InValid = 0; t = 2;
    v0 = OutValid; o0 = Out;
    Enable = 0;
    #1;
    checks++;
    if (InReady !== 1'b0) begin
      errors++;
      $display("FAIL en_inready: got %b want 0", InReady);
    end
    repeat (2) begin
      tick(); t++;
      checks++;
      if (OutValid !== v0 || Out !== o0) begin
        errors++;
        $display("FAIL en_frozen: got v=%b out=%h want v=%b out=%h", OutValid, Out, v0, o0);
      end
    end
    Enable = 1;
    while (OutValid !== 1'b1 && t < 60) begin
      tick(); t++;
    end
    checks++;
    if (t != S + 2) begin
      errors++;
      $display("FAIL en_latency: got %0d want %0d", t, S + 2);
    end
    checks++;
    if (Out !== 32'd30) begin
      errors++;
      $display("FAIL en_first: got %0d want 30", Out);
    end
    tick();
    checks++;
    if (OutValid !== 1'b1 || Out !== 32'd70) begin
      errors++;
      $display("FAIL en_second: got v=%b out=%0d want v=1 out=70", OutValid, Out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    res_t got; int lat; int bad;
    Enable = 1; OutReady = 0; CI = 0; Sub = 0;
    for (int i = 1; i <= 3; i++) begin
      In1 = W'(i); In2 = W'(i); InValid = 1;
      tick();
    end
    InValid = 0;
    while (OutValid !== 1'b1 && lat < 20) begin
      tick(); lat++;
    end
    #1 RST = 1;
    #1;
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outvalid: got %b want 0", OutValid);
    end
    #3 RST = 0;
    OutReady = 1;
    bad = 0;
    repeat (8) begin
      tick();
      if (OutValid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid_stale: got %0d stale OutValid cycles want 0", bad);
    end
    do_op(32'd100, 32'd23, 1'b0, 1'b0, got, lat);
    checks++;
    if (got.out !== 32'd123 || lat !== S) begin
      errors++;
      $display("FAIL rst_mid_new_op: got out=%0d lat=%0d want out=123 lat=%0d", got.out, lat, S);
    end
  endtask

  task automatic test_random();
    res_t exp_q[$];
    res_t e;
    int guard;
    for (int cyc = 0; cyc < 400; cyc++) begin
      Enable   = ($urandom_range(0, 9) != 0);
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      In1 = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
      In2 = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
      CI  = 1'($urandom);
      Sub = 1'($urandom);
      #1;
      checks++;
      if (InReady !== (Enable && (!OutValid || OutReady))) begin
        errors++;
        $display("FAIL rnd_inready: got %b want %b (cycle %0d)", InReady,
                 Enable && (!OutValid || OutReady), cyc);
      end
      if (OutValid && OutReady && Enable) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious: got result %h want none", Out);
        end else begin
          e = exp_q.pop_front();
          if ({Out, CO, OV} !== e) begin
            errors++;
            $display("FAIL rnd_result: got %h/%b/%b want %h/%b/%b", Out, CO, OV, e.out, e.co, e.ov);
          end
        end
      end
      if (InValid && InReady) exp_q.push_back(model(In1, In2, CI, Sub));
      tick();
    end
    InValid = 0; Enable = 1; OutReady = 1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      #1;
      if (OutValid) begin
        e = exp_q.pop_front();
        checks++;
        if ({Out, CO, OV} !== e) begin
          errors++;
          $display("FAIL rnd_drain: got %h/%b/%b want %h/%b/%b", Out, CO, OV, e.out, e.co, e.ov);
        end
      end
      tick();
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_lost: got %0d results missing want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ripple();
    test_subtract();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
